// File: rtl/spiflash_host.sv
// spiflash_host: SPI mode-0 host that shifts 48-bit {address, command, data} frames MSB first
// and returns read data on a one-cycle RspValid pulse.
// Optional SPIFLASH_HOST_CHAIN_EN: a request presented in the last HOLD cycle is accepted there,
// keeping CS low and skipping GAP so frames run back to back.
module spiflash_host #(
    parameter int unsigned CLKDIV    = 2,
    parameter logic [7:0]  CMD_READ  = 8'h01,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAdr,
    input  logic [7:0]  ReqWData,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic        SCLK,
    output logic        CS,
    output logic        MOSI,
    input  logic        MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [47:0] shift_q, shift_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        expire;
    logic        hold_last;
    logic        accept;
    logic [47:0] frame;

    assign expire    = div_q == 8'd0;
    assign hold_last = (state_q == HOLD) && expire;
`ifdef SPIFLASH_HOST_CHAIN_EN
    assign ReqReady  = ready_q | (hold_last & ReqValid);
`else
    assign ReqReady  = ready_q;
`endif
    assign accept    = ReqValid & ReqReady;
    assign frame     = {ReqAdr, ReqWrite ? CMD_WRITE : CMD_READ, ReqWrite ? ReqWData : 8'h00};

    assign CS       = cs_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;

    // Next state: half-period divider, SCLK toggling, shift/capture and frame start
    always_comb begin
        state_d     = state_q;
        div_d       = expire ? DIV_LOAD : div_q - 8'd1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        wr_d        = wr_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: div_d = DIV_LOAD;
            SETUP: if (expire) state_d = SHIFT;
            SHIFT: begin
                if (expire && !sclk_q) begin
                    sclk_d = 1'b1;
                    bit_d  = bit_q + 6'd1;
                    if (bit_q >= 6'd40) rdata_d = {rdata_q[6:0], MISO};
                end else if (expire) begin
                    sclk_d  = 1'b0;
                    shift_d = {shift_q[46:0], 1'b0};
                    mosi_d  = shift_q[46];
                    if (bit_q == 6'd48) state_d = HOLD;
                end
            end
            HOLD: begin
                if (expire) begin
                    state_d     = GAP;
                    cs_d        = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wr_q ? 8'h00 : rdata_q;
                end
            end
            GAP: if (expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = SETUP;
            div_d   = DIV_LOAD;
            bit_d   = 6'd0;
            shift_d = frame;
            wr_d    = ReqWrite;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = frame[47];
        end
        ready_d = state_d == IDLE;
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            bit_q       <= 6'd0;
            shift_q     <= 48'd0;
            rdata_q     <= 8'd0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            wr_q        <= wr_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_spiflash_host.sv
// tb_spiflash_host: scoreboard bench for spiflash_host, instance 0 at CLKDIV=2 and instance 1 at
// CLKDIV=1, each attached to a behavioural SPI flash model
module tb_spiflash_host;
    localparam int NI = 2;
    localparam int DIV [NI] = '{2, 1};

    logic        clk = 1'b0;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_write [NI];
    logic [31:0] req_adr   [NI];
    logic [7:0]  req_wdata [NI];
    logic        req_ready [NI];
    logic        rsp_valid [NI];
    logic [7:0]  rsp_data  [NI];
    logic        sclk      [NI];
    logic        cs        [NI];
    logic        mosi      [NI];

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] ref_mem [logic [32:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : b
        logic        miso_l = 1'b0;
        logic [47:0] sh = 48'd0;
        logic [7:0]  dout = 8'd0;
        logic [7:0]  mem [int unsigned];
        logic [7:0]  exp_rsp [$];
        logic [47:0] exp_frame [$];
        int          acc_cyc [$];
        int          nb = 0, rsps = 0, cs_low = 0, cs_falls = 0, sclk_bad = 0;
        int          run_exp = 98 * DIV[g];
        bit          abort = 1'b0;
        logic        prev_cs = 1'b1, prev_sclk = 1'b0;

        spiflash_host #(.CLKDIV(DIV[g])) u_dut (
            .clk(clk), .reset(rst[g]), .ReqValid(req_valid[g]), .ReqReady(req_ready[g]),
            .ReqWrite(req_write[g]), .ReqAdr(req_adr[g]), .ReqWData(req_wdata[g]),
            .RspValid(rsp_valid[g]), .RspData(rsp_data[g]), .SCLK(sclk[g]), .CS(cs[g]),
            .MOSI(mosi[g]), .MISO(miso_l)
        );

        // Flash model: sample MOSI on SCLK rise, commit writes and check the frame after bit 48
        always @(negedge cs[g] or posedge sclk[g]) begin
            if (!sclk[g]) nb = 0;
            else if (!cs[g]) begin
                sh = {sh[46:0], mosi[g]};
                nb++;
                if (nb == 48) begin
                    if (sh[15:8] == 8'h02) mem[sh[47:16]] = sh[7:0];
                    if (exp_frame.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame_bits", sh, exp_frame.pop_front());
                    nb = 0;
                end
            end
        end

        // Flash model: drive read data MSB first after each falling edge of the data phase
        always @(negedge sclk[g]) begin
            if (!cs[g] && nb >= 40) begin
                if (nb == 40) dout = mem.exists(sh[39:8]) ? mem[sh[39:8]] : ~sh[15:8];
                miso_l = dout[47 - nb];
            end
        end

        // Bus monitor: CS-low run length, SCLK quiet while deselected, responses and latency
        always @(negedge clk) begin
            if (!cs[g]) cs_low++;
            if (cs[g] && cs_low != 0) begin
                if (!abort) check("cs_low_cycles", cs_low, run_exp);
                abort = 1'b0;
                cs_low = 0;
            end
            if (prev_cs && !cs[g]) cs_falls++;
            if (cs[g] && prev_cs && (sclk[g] || prev_sclk)) sclk_bad++;
            prev_cs = cs[g];
            prev_sclk = sclk[g];
            if (rsp_valid[g]) begin
                rsps++;
                if (exp_rsp.size() == 0 || acc_cyc.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    check("rsp_data", rsp_data[g], exp_rsp.pop_front());
                    check("rsp_latency", cyc - acc_cyc.pop_front(), 1 + 98 * DIV[g]);
                end
            end
            if (req_valid[g] && req_ready[g] && !rst[g]) acc_cyc.push_back(cyc);
        end
    end

    task automatic expect_frame(input int g, input bit wr, input logic [31:0] adr, input logic [7:0] wd);
        logic [32:0] k;
        logic [7:0]  r;
        logic [47:0] f;
        k = {g[0], adr};
        r = wr ? 8'h00 : (ref_mem.exists(k) ? ref_mem[k] : ~adr[7:0]);
        f = {adr, wr ? 8'h02 : 8'h01, wr ? wd : 8'h00};
        if (wr) ref_mem[k] = wd;
        if (g == 0) begin
            b[0].exp_rsp.push_back(r);
            b[0].exp_frame.push_back(f);
        end else begin
            b[1].exp_rsp.push_back(r);
            b[1].exp_frame.push_back(f);
        end
    endtask

    task automatic issue(input int g, input bit wr, input logic [31:0] adr, input logic [7:0] wd);
        bit ok;
        ok = 1'b0;
        req_write[g] = wr;
        req_adr[g] = adr;
        req_wdata[g] = wd;
        req_valid[g] = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[g];
            @(posedge clk);
            #1;
        end
        check("accept_timeout", ok, 1);
    endtask

    task automatic drain(input int g);
        int n;
        n = 0;
        while ((g == 0 ? b[0].exp_rsp.size() : b[1].exp_rsp.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", n < 2000, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic txn(input int g, input bit wr, input logic [31:0] adr, input logic [7:0] wd);
        expect_frame(g, wr, adr, wd);
        issue(g, wr, adr, wd);
        req_valid[g] = 1'b0;
        drain(g);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f1, n;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_adr[i] = 32'd0;
            req_wdata[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_mosi", mosi[0], 0);
        check("rst_ready", req_ready[0], 0);
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_rsp_data", rsp_data[0], 0);
        check("rst_cs_div1", cs[1], 1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        check("ready_before_edge", req_ready[0], 0);
        @(posedge clk);
        #1;
        check("ready_after_release", req_ready[0], 1);

        txn(0, 1'b1, 32'h0000_0010, 8'hA5);
        r0 = b[0].rsps;
        txn(0, 1'b0, 32'h0000_0010, 8'h00);
        check("single_rsp_pulse", b[0].rsps - r0, 1);

        txn(0, 1'b1, 32'h0000_0000, 8'h3C);
        txn(0, 1'b1, 32'h0000_00FF, 8'hC3);
        txn(0, 1'b0, 32'h0000_0000, 8'h00);
        txn(0, 1'b0, 32'h0000_00FF, 8'h00);

        expect_frame(0, 1'b1, 32'h1234_5678, 8'h5A);
        issue(0, 1'b1, 32'h1234_5678, 8'h5A);
        req_valid[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        req_adr[0] = 32'hDEAD_BEEF;
        req_write[0] = 1'b0;
        req_valid[0] = 1'b1;
        check("busy_ready", req_ready[0], 0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        drain(0);
        txn(0, 1'b0, 32'h1234_5678, 8'h00);

        r0 = b[0].rsps;
        issue(0, 1'b1, 32'h0000_0010, 8'h77);
        req_valid[0] = 1'b0;
        n = 0;
        while (b[0].nb != 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rise20_timeout", n < 1000, 1);
        b[0].abort = 1'b1;
        rst[0] = 1'b1;
        #1;
        check("abort_cs", cs[0], 1);
        check("abort_sclk", sclk[0], 0);
        check("abort_mosi", mosi[0], 0);
        check("abort_rsp_valid", rsp_valid[0], 0);
        b[0].acc_cyc.delete();
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        #1;
        check("abort_ready_low", req_ready[0], 0);
        @(posedge clk);
        #1;
        check("abort_ready_high", req_ready[0], 1);
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_rsp", b[0].rsps - r0, 0);
        txn(0, 1'b0, 32'h0000_0010, 8'h00);

        txn(1, 1'b1, 32'h0000_0101, 8'h42);
`ifdef SPIFLASH_HOST_CHAIN_EN
        b[1].run_exp = 3 * 98;
`endif
        r0 = b[1].rsps;
        f1 = b[1].cs_falls;
        for (int i = 0; i < 3; i++) begin
            expect_frame(1, 1'b0, 32'h0000_0100 + i, 8'h00);
            issue(1, 1'b0, 32'h0000_0100 + i, 8'h00);
        end
        req_valid[1] = 1'b0;
        drain(1);
        check("chain_rsps", b[1].rsps - r0, 3);
`ifdef SPIFLASH_HOST_CHAIN_EN
        check("chain_cs_falls", b[1].cs_falls - f1, 1);
`else
        check("chain_cs_falls", b[1].cs_falls - f1, 3);
`endif

        check("sclk_quiet_div2", b[0].sclk_bad, 0);
        check("sclk_quiet_div1", b[1].sclk_bad, 0);
        check("frames_left_div2", b[0].exp_frame.size(), 0);
        check("frames_left_div1", b[1].exp_frame.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
